mcctrl: RTL and testbench

- Multi-cycle control FSM that sequences the shared MIPS datapath: one ALU, one unified memory, register file, IR/MDR/ALUOut registers.
- It replaces the single-cycle combinational decoder.
- It issues per-state datapath selects and enables, and waits on a memory ready handshake.
- It sits beside the datapath top, driven by IR opcode/funct and the ALU Zero flag.

---
 rtl/mcctrl_pkg.sv | 63 ++++++
 rtl/mcctrl_aludec.sv | 23 ++
 rtl/mcctrl.sv | 207 ++++++++++++++++++++
 tb/tb_mcctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mcctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, ALU ops, opcodes and datapath select codes.
// S_JAL is only reachable when MCCTRL_JAL_EN is defined.
package mcctrl_pkg;

   typedef enum logic [3:0] {
      S_RST    = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MADDR  = 4'd3,
      S_MRD    = 4'd4,
      S_MWB    = 4'd5,
      S_MWR    = 4'd6,
      S_EXE    = 4'd7,
      S_RWB    = 4'd8,
      S_IEXE   = 4'd9,
      S_IWB    = 4'd10,
      S_BEQ    = 4'd11,
      S_JMP    = 4'd12,
      S_JAL    = 4'd13
   } state_t;

   localparam logic [2:0] ALU_NOP = 3'b000;
   localparam logic [2:0] ALU_ADD = 3'b001;
   localparam logic [2:0] ALU_SUB = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_OR  = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLT  = 6'b101010;

   localparam logic [1:0] ASRCB_B     = 2'b00;
   localparam logic [1:0] ASRCB_4     = 2'b01;
   localparam logic [1:0] ASRCB_IMM   = 2'b10;
   localparam logic [1:0] ASRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] GPR_RD = 2'b00;
   localparam logic [1:0] GPR_RT = 2'b01;
   localparam logic [1:0] GPR_RA = 2'b10;

   localparam logic [1:0] WD_ALUOUT = 2'b00;
   localparam logic [1:0] WD_MDR    = 2'b01;
   localparam logic [1:0] WD_PC     = 2'b10;

endpackage

// File: rtl/mcctrl_aludec.sv
// R-type function decode: maps Funct to an ALU operation, flags unsupported codes.
module mcctrl_aludec
   import mcctrl_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alu_op,
   output logic       valid
);

   always_comb begin
      alu_op = ALU_NOP;
      valid  = 1'b1;
      case (funct)
         FN_ADD, FN_ADDU: alu_op = ALU_ADD;
         FN_SUB, FN_SUBU: alu_op = ALU_SUB;
         FN_AND:          alu_op = ALU_AND;
         FN_OR:           alu_op = ALU_OR;
         FN_SLT:          alu_op = ALU_SLT;
         default:         valid  = 1'b0;
      endcase
   end

endmodule

// File: rtl/mcctrl.sv
// Multi-cycle control FSM for the shared-ALU / unified-memory MIPS datapath.
// Optional jal support is enabled by defining MCCTRL_JAL_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_RST    | reset, all outputs idle
// S_FETCH  | read IR at PC, PC <= PC+4 when memory is ready
// S_DECODE | dispatch on Op, branch target into ALUOut
// S_MADDR  | effective address A + sext(imm)
// S_MRD    | load data read at ALUOut
// S_MWB    | load write-back to rt from MDR
// S_MWR    | store write at ALUOut
// S_EXE    | R-type ALU operation
// S_RWB    | R-type write-back to rd
// S_IEXE   | addi / ori ALU operation
// S_IWB    | immediate write-back to rt
// S_BEQ    | compare, PC <= ALUOut when equal
// S_JMP    | PC <= jump target
// S_JAL    | PC <= jump target, r31 <= PC (optional)
module mcctrl
   import mcctrl_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         Op,
   input  logic [5:0]         Funct,
   input  logic               Zero,
   input  logic               mem_ready,
   output logic               PCWr,
   output logic               IRWrite,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               RegWrite,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [2:0]         ALUOp,
   output logic [1:0]         PCSource,
   output logic               EXTOp,
   output logic [1:0]         GPRSel,
   output logic [1:0]         WDSel,
   output logic               illegal,
   output logic [STATE_W-1:0] state_dbg
);

   state_t     state_q;
   state_t     state_n;
   logic [2:0] fn_alu_op;
   logic       fn_valid;

   mcctrl_aludec u_aludec (
      .funct  (Funct),
      .alu_op (fn_alu_op),
      .valid  (fn_valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_RST;
      else     state_q <= state_n;
   end

   always_comb begin
      state_n = S_FETCH;
      case (state_q)
         S_RST:   state_n = S_FETCH;
         S_FETCH: state_n = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (Op)
               OP_LW, OP_SW:    state_n = S_MADDR;
               OP_RTYPE:        state_n = S_EXE;
               OP_ADDI, OP_ORI: state_n = S_IEXE;
               OP_BEQ:          state_n = S_BEQ;
               OP_J:            state_n = S_JMP;
`ifdef MCCTRL_JAL_EN
               OP_JAL:          state_n = S_JAL;
`endif
               default:         state_n = S_FETCH;
            endcase
         end
         S_MADDR: state_n = (Op == OP_SW) ? S_MWR : S_MRD;
         S_MRD:   state_n = mem_ready ? S_MWB : S_MRD;
         S_MWB:   state_n = S_FETCH;
         S_MWR:   state_n = mem_ready ? S_FETCH : S_MWR;
         S_EXE:   state_n = fn_valid ? S_RWB : S_FETCH;
         S_RWB:   state_n = S_FETCH;
         S_IEXE:  state_n = S_IWB;
         S_IWB:   state_n = S_FETCH;
         S_BEQ:   state_n = S_FETCH;
         S_JMP:   state_n = S_FETCH;
`ifdef MCCTRL_JAL_EN
         S_JAL:   state_n = S_FETCH;
`endif
         default: state_n = S_FETCH;
      endcase
   end

   always_comb begin
      PCWr     = 1'b0;
      IRWrite  = 1'b0;
      IorD     = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = ASRCB_B;
      ALUOp    = ALU_NOP;
      PCSource = PCSRC_ALU;
      EXTOp    = 1'b0;
      GPRSel   = GPR_RD;
      WDSel    = WD_ALUOUT;
      illegal  = 1'b0;
      case (state_q)
         S_FETCH: begin
            MemRead  = 1'b1;
            ALUSrcB  = ASRCB_4;
            ALUOp    = ALU_ADD;
            PCSource = PCSRC_ALU;
            IRWrite  = mem_ready;
            PCWr     = mem_ready;
         end
         S_DECODE: begin
            ALUSrcB = ASRCB_IMMSH;
            ALUOp   = ALU_ADD;
            EXTOp   = 1'b1;
            case (Op)
               OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_ORI, OP_BEQ, OP_J: illegal = 1'b0;
`ifdef MCCTRL_JAL_EN
               OP_JAL:  illegal = 1'b0;
`endif
               default: illegal = 1'b1;
            endcase
         end
         S_MADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = ASRCB_IMM;
            EXTOp   = 1'b1;
            ALUOp   = ALU_ADD;
         end
         S_MRD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
         end
         S_MWB: begin
            RegWrite = 1'b1;
            GPRSel   = GPR_RT;
            WDSel    = WD_MDR;
         end
         S_MWR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         S_EXE: begin
            ALUSrcA = 1'b1;
            ALUSrcB = ASRCB_B;
            ALUOp   = fn_alu_op;
            illegal = ~fn_valid;
         end
         S_RWB: begin
            RegWrite = 1'b1;
            GPRSel   = GPR_RD;
            WDSel    = WD_ALUOUT;
         end
         S_IEXE: begin
            ALUSrcA = 1'b1;
            ALUSrcB = ASRCB_IMM;
            if (Op == OP_ORI) begin
               EXTOp = 1'b0;
               ALUOp = ALU_OR;
            end else begin
               EXTOp = 1'b1;
               ALUOp = ALU_ADD;
            end
         end
         S_IWB: begin
            RegWrite = 1'b1;
            GPRSel   = GPR_RT;
            WDSel    = WD_ALUOUT;
         end
         S_BEQ: begin
            ALUSrcA  = 1'b1;
            ALUSrcB  = ASRCB_B;
            ALUOp    = ALU_SUB;
            PCSource = PCSRC_ALUOUT;
            PCWr     = Zero;
         end
         S_JMP: begin
            PCSource = PCSRC_JUMP;
            PCWr     = 1'b1;
         end
`ifdef MCCTRL_JAL_EN
         S_JAL: begin
            PCSource = PCSRC_JUMP;
            PCWr     = 1'b1;
            RegWrite = 1'b1;
            GPRSel   = GPR_RA;
            WDSel    = WD_PC;
         end
`endif
         default: ;
      endcase
   end

   assign state_dbg = STATE_W'(state_q);

endmodule

// File: tb/tb_mcctrl.sv
// Scoreboard bench for mcctrl: per-instruction cycle sequences from an instruction-level model.
// Honours MCCTRL_JAL_EN in the same way as the design.
module tb_mcctrl;
   import mcctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] Op = '0;
   logic [5:0] Funct = '0;
   logic       Zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       PCWr, IRWrite, IorD, MemRead, MemWrite, RegWrite, ALUSrcA, EXTOp, illegal;
   logic [1:0] ALUSrcB, PCSource, GPRSel, WDSel;
   logic [2:0] ALUOp;
   logic [3:0] state_dbg;

   typedef struct packed {
      logic       pcwr, irwrite, iord, memread, memwrite, regwrite, alusrca;
      logic [1:0] alusrcb;
      logic [2:0] aluop;
      logic [1:0] pcsource;
      logic       extop;
      logic [1:0] gprsel, wdsel;
      logic       illegal;
   } out_t;

   typedef struct packed {
      logic [3:0] st;
      out_t       o;
   } rec_t;

   rec_t sb[$];
   int   checks = 0;
   int   fails  = 0;

   mcctrl #(.STATE_W(4)) dut (
      .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
      .PCWr(PCWr), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .EXTOp(EXTOp), .GPRSel(GPRSel), .WDSel(WDSel),
      .illegal(illegal), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   function automatic logic op_known(input logic [5:0] op);
      case (op)
         OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_ORI, OP_BEQ, OP_J: return 1'b1;
`ifdef MCCTRL_JAL_EN
         OP_JAL: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

   // ALU operation the instruction set assigns to each supported R-type function.
   function automatic logic [3:0] fn_op(input logic [5:0] fn);
      case (fn)
         6'b100000, 6'b100001: return {1'b1, 3'b001};
         6'b100010, 6'b100011: return {1'b1, 3'b010};
         6'b100100:            return {1'b1, 3'b011};
         6'b100101:            return {1'b1, 3'b100};
         6'b101010:            return {1'b1, 3'b101};
         default:              return 4'b0000;
      endcase
   endfunction

   function automatic out_t exp_out(input state_t s, input logic mr, input logic z,
                                    input logic [5:0] op, input logic [5:0] fn);
      out_t e;
      logic [3:0] f;
      e = '0;
      f = fn_op(fn);
      case (s)
         S_FETCH:  begin e.memread = 1; e.alusrcb = 2'b01; e.aluop = 3'b001; e.irwrite = mr; e.pcwr = mr; end
         S_DECODE: begin e.alusrcb = 2'b11; e.aluop = 3'b001; e.extop = 1; e.illegal = ~op_known(op); end
         S_MADDR:  begin e.alusrca = 1; e.alusrcb = 2'b10; e.extop = 1; e.aluop = 3'b001; end
         S_MRD:    begin e.iord = 1; e.memread = 1; end
         S_MWB:    begin e.regwrite = 1; e.gprsel = 2'b01; e.wdsel = 2'b01; end
         S_MWR:    begin e.iord = 1; e.memwrite = 1; end
         S_EXE:    begin e.alusrca = 1; e.aluop = f[2:0]; e.illegal = ~f[3]; end
         S_RWB:    begin e.regwrite = 1; end
         S_IEXE:   begin
            e.alusrca = 1; e.alusrcb = 2'b10;
            e.extop = (op == OP_ADDI);
            e.aluop = (op == OP_ORI) ? 3'b100 : 3'b001;
         end
         S_IWB:    begin e.regwrite = 1; e.gprsel = 2'b01; end
         S_BEQ:    begin e.alusrca = 1; e.aluop = 3'b010; e.pcsource = 2'b01; e.pcwr = z; end
         S_JMP:    begin e.pcsource = 2'b10; e.pcwr = 1; end
         S_JAL:    begin e.pcsource = 2'b10; e.pcwr = 1; e.regwrite = 1; e.gprsel = 2'b10; e.wdsel = 2'b10; end
         default:  e = '0;
      endcase
      return e;
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push_exp(input state_t s, input logic mr, input logic z);
      rec_t r;
      mem_ready = mr;
      Zero      = z;
      r.st = s;
      r.o  = exp_out(s, mr, z, Op, Funct);
      sb.push_back(r);
   endtask

   task automatic cyc(input state_t s, input logic mr, input logic z);
      push_exp(s, mr, z);
      @(posedge clk);
      #1;
   endtask

   // One instruction end to end: fetch wait states wf, data-memory wait states wm.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int wf,
                            input int wm, input logic z);
      Op = op;
      Funct = fn;
      repeat (wf) cyc(S_FETCH, 1'b0, rb());
      cyc(S_FETCH, 1'b1, rb());
      cyc(S_DECODE, rb(), rb());
      if (op == OP_LW) begin
         cyc(S_MADDR, rb(), rb());
         repeat (wm) cyc(S_MRD, 1'b0, rb());
         cyc(S_MRD, 1'b1, rb());
         cyc(S_MWB, rb(), rb());
      end else if (op == OP_SW) begin
         cyc(S_MADDR, rb(), rb());
         repeat (wm) cyc(S_MWR, 1'b0, rb());
         cyc(S_MWR, 1'b1, rb());
      end else if (op == OP_RTYPE) begin
         cyc(S_EXE, rb(), rb());
         if (fn_op(fn) != 4'b0000) cyc(S_RWB, rb(), rb());
      end else if (op == OP_ADDI || op == OP_ORI) begin
         cyc(S_IEXE, rb(), rb());
         cyc(S_IWB, rb(), rb());
      end else if (op == OP_BEQ) begin
         cyc(S_BEQ, rb(), z);
      end else if (op == OP_J) begin
         cyc(S_JMP, rb(), rb());
      end else if (op_known(op)) begin
         cyc(S_JAL, rb(), rb());
      end
   endtask

   task automatic reset_release();
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc(S_RST, rb(), rb());
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         rec_t e;
         out_t a;
         e = sb.pop_front();
         a = '{PCWr, IRWrite, IorD, MemRead, MemWrite, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, EXTOp, GPRSel, WDSel, illegal};
         checks++;
         if (state_dbg !== e.st) begin
            fails++;
            $display("FAIL state: got %0d expected %0d at %0t", state_dbg, e.st, $time);
         end
         checks++;
         if (a !== e.o) begin
            fails++;
            $display("FAIL outputs in state %0d: got %h expected %h (Op=%b Funct=%b) at %0t",
                     e.st, a, e.o, Op, Funct, $time);
         end
      end
   end

   logic [5:0] op_tab [9];
   logic [5:0] fn_tab [7];

   initial begin
      op_tab = '{OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_ORI, OP_BEQ, OP_J, OP_JAL, 6'b111111};
      fn_tab = '{FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_SLT};

      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({PCWr, IRWrite, MemRead, MemWrite, RegWrite, illegal, state_dbg} !== 10'd0) begin
         fails++;
         $display("FAIL reset idle: got %b expected 0",
                  {PCWr, IRWrite, MemRead, MemWrite, RegWrite, illegal, state_dbg});
      end
      reset_release();

      run_instr(OP_RTYPE, FN_ADD, 0, 0, 1'b0);
      run_instr(OP_LW, 6'd0, 2, 3, 1'b0);
      run_instr(OP_SW, 6'd0, 0, 0, 1'b0);
      run_instr(OP_BEQ, 6'd0, 0, 0, 1'b1);
      run_instr(OP_BEQ, 6'd0, 0, 0, 1'b0);
      run_instr(6'b111111, 6'd0, 0, 0, 1'b0);
      run_instr(OP_JAL, 6'd0, 0, 0, 1'b0);
      run_instr(OP_ORI, 6'd0, 1, 0, 1'b0);
      run_instr(OP_RTYPE, 6'b000111, 0, 0, 1'b0);

      // Reset while a store is waiting on memory must drop MemWrite immediately.
      Op = OP_SW;
      cyc(S_FETCH, 1'b1, 1'b0);
      cyc(S_DECODE, 1'b0, 1'b0);
      cyc(S_MADDR, 1'b0, 1'b0);
      push_exp(S_MWR, 1'b0, 1'b0);
      #6;
      rst = 1'b1;
      #1;
      checks++;
      if (MemWrite !== 1'b0 || state_dbg !== 4'd0) begin
         fails++;
         $display("FAIL async reset in MWR: MemWrite=%b state=%0d expected 0/0", MemWrite, state_dbg);
      end
      reset_release();
      run_instr(OP_ADDI, 6'd0, 0, 0, 1'b0);

      for (int i = 0; i < 200; i++) begin
         logic [5:0] op, fn;
         op = (i % 10 == 9) ? 6'($urandom) : op_tab[$urandom_range(0, 8)];
         fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 6)];
         run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), rb());
      end

      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
